// File: rtl/digit_step_ctrl_pkg.sv
// digit_step_pkg: shared types and helpers for the digit stepper.
//   DIGIT_W     width of the displayed digit
//   run_state_t run/pause state of the auto-advance FSM
//   step_t      kind of digit step chosen in a cycle
//   next_digit  wrap-around step over 0..max
package digit_step_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic {ST_PAUSED, ST_RUNNING} run_state_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN} step_t;

  function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] cur,
                                                    input step_t            step,
                                                    input logic [DIGIT_W-1:0] max);
    logic [DIGIT_W-1:0] r;
    r = cur;
    case (step)
      STEP_UP:   r = (cur == max) ? '0 : cur + DIGIT_W'(1);
      STEP_DOWN: r = (cur == '0) ? max : cur - DIGIT_W'(1);
      default:   r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/digit_step_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, debounce counter and press-pulse edge
// detect for one bouncy push-button.
//   clk, rst_n  clock, synchronous active-low reset
//   raw         asynchronous active-high button input
//   level       debounced button level
//   press       one-cycle pulse, registered one cycle after level rises
module btn_debounce #(
  parameter int DEB_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample agreeing with the accepted level restarts the count; the
      // DEB_CYCLES-th consecutive disagreeing sample flips the level.
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/digit_step_ctrl.sv
// digit_step_ctrl: user-controllable 4-bit digit source for the seven-segment
// decoder. Debounces up/down/run buttons, auto-advances on a prescaled tick
// while running, wraps over 0..MAX_DIGIT.
//   clk, rst_n    clock, synchronous active-low reset
//   btn_up_raw    bouncy button: step digit up
//   btn_down_raw  bouncy button: step digit down
//   btn_run_raw   bouncy button: toggle run/pause
//   digit         current digit
//   digit_chg     one-cycle pulse with each new digit value
//   running       1 while auto-advance is active
// Build option: define AUTOREPEAT_EN to make held up/down buttons repeat
// REPEAT_DELAY cycles after the press, then every REPEAT_RATE cycles.
module digit_step_ctrl
  import digit_step_pkg::*;
#(
  parameter int TICK_DIV     = 10_000_000,
  parameter int DEB_CYCLES   = 50_000,
  parameter int MAX_DIGIT    = 6,
  parameter int REPEAT_DELAY = 5_000_000,
  parameter int REPEAT_RATE  = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_run_raw,
  output logic [3:0] digit,
  output logic       digit_chg,
  output logic       running
);

  if (MAX_DIGIT < 1 || MAX_DIGIT > 15) begin : g_bad_max
    $error("digit_step_ctrl: MAX_DIGIT must be within 1..15");
  end
  if (TICK_DIV < 2 || DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("digit_step_ctrl: TICK_DIV>=2, DEB_CYCLES>=1, REPEAT_DELAY>=1, REPEAT_RATE>=1 required");
  end

  localparam int                 PW    = $clog2(TICK_DIV);
  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

  logic [2:0] level;
  logic [2:0] press;
  logic       up_ev;
  logic       down_ev;
  logic       tick;
  step_t      step;
  run_state_t state;
  logic [PW-1:0] presc;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst_n(rst_n), .raw(btn_up_raw), .level(level[0]), .press(press[0])
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst_n(rst_n), .raw(btn_down_raw), .level(level[1]), .press(press[1])
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst_n(rst_n), .raw(btn_run_raw), .level(level[2]), .press(press[2])
  );

  // Only the up/down levels feed auto-repeat; the run level is never needed.
  logic unused_levels;
  assign unused_levels = &{1'b0, level};

`ifdef AUTOREPEAT_EN
  logic [1:0] rep;

  for (genvar i = 0; i < 2; i++) begin : g_rep
    logic [31:0] hold_cnt;
    logic        rate_phase;

    // hold_cnt is the number of cycles since the last press/repeat step.
    assign rep[i] = (hold_cnt == (rate_phase ? 32'(REPEAT_RATE) : 32'(REPEAT_DELAY)));

    always_ff @(posedge clk) begin
      if (!rst_n || !level[i]) begin
        hold_cnt   <= '0;
        rate_phase <= 1'b0;
      end else if (press[i]) begin
        hold_cnt   <= 32'd1;
        rate_phase <= 1'b0;
      end else if (rep[i]) begin
        hold_cnt   <= 32'd1;
        rate_phase <= 1'b1;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt + 32'd1;
      end
    end
  end

  assign up_ev   = press[0] | rep[0];
  assign down_ev = press[1] | rep[1];
`else
  assign up_ev   = press[0];
  assign down_ev = press[1];
`endif

  assign tick = (state == ST_RUNNING) && (presc == PW'(TICK_DIV - 1));

  always_comb begin
    step = STEP_NONE;
    if (up_ev)        step = STEP_UP;
    else if (down_ev) step = STEP_DOWN;
    else if (tick)    step = STEP_UP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUNNING;
      running   <= 1'b1;
      presc     <= '0;
      digit     <= '0;
      digit_chg <= 1'b0;
    end else begin
      digit_chg <= (step != STEP_NONE);
      if (step != STEP_NONE) digit <= next_digit(digit, step, MAX_D);

      // Tick and prescaler use the pre-toggle state even when run is pressed.
      if (up_ev || down_ev)        presc <= '0;
      else if (state == ST_RUNNING) presc <= tick ? '0 : presc + PW'(1);

      if (press[2]) begin
        state   <= (state == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
        running <= (state != ST_RUNNING);
      end
    end
  end

endmodule

// File: tb/tb_digit_step_ctrl.sv
module tb_digit_step_ctrl;

  localparam int TICK_DIV     = 8;
  localparam int DEB_CYCLES   = 4;
  localparam int MAX_DIGIT    = 6;
  localparam int REPEAT_DELAY = 10;
  localparam int REPEAT_RATE  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up_raw = 1'b0;
  logic       btn_down_raw = 1'b0;
  logic       btn_run_raw = 1'b0;
  logic [3:0] digit;
  logic       digit_chg;
  logic       running;

  int n_err = 0;
  int n_chk = 0;
  int edge_no = 0;

  digit_step_ctrl #(
    .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES), .MAX_DIGIT(MAX_DIGIT),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw), .btn_run_raw(btn_run_raw),
    .digit(digit), .digit_chg(digit_chg), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Reference model, advanced once per rising edge from the sampled inputs.
  // Button timing: a raw level is seen by the debouncer two edges later; after
  // DEB_CYCLES consecutive disagreeing samples the level flips, and a rising
  // flip at edge F acts on the digit at edge F+2.
  int m_digit = 0;
  int m_presc = 0;
  bit m_run = 1'b1;
  bit m_chg = 1'b0;
  bit h1[3], h2[3], lvl[3];
  int cnt[3];
  int due_q[3][$];
  int rep_start[2];
  int rep_kill[2];

  task automatic model_step();
    bit raw[3];
    bit ev[3];
    bit tick;
    bit d;
    raw[0] = btn_up_raw;
    raw[1] = btn_down_raw;
    raw[2] = btn_run_raw;
    edge_no++;
    if (!rst_n) begin
      m_digit = 0; m_presc = 0; m_run = 1'b1; m_chg = 1'b0;
      for (int b = 0; b < 3; b++) begin
        h1[b] = 1'b0; h2[b] = 1'b0; lvl[b] = 1'b0; cnt[b] = 0;
        due_q[b].delete();
      end
      for (int b = 0; b < 2; b++) rep_kill[b] = 0;
      return;
    end
    for (int b = 0; b < 3; b++) begin
      ev[b] = 1'b0;
      while (due_q[b].size() > 0 && due_q[b][0] == edge_no) begin
        ev[b] = 1'b1;
        void'(due_q[b].pop_front());
      end
    end
`ifdef AUTOREPEAT_EN
    for (int b = 0; b < 2; b++) begin
      int age;
      age = edge_no - rep_start[b];
      if (edge_no < rep_kill[b] &&
          (age == REPEAT_DELAY || (age > REPEAT_DELAY && (age - REPEAT_DELAY) % REPEAT_RATE == 0)))
        ev[b] = 1'b1;
    end
`endif
    tick = m_run && (m_presc == TICK_DIV - 1);
    m_chg = ev[0] || ev[1] || tick;
    if (ev[0] || (!ev[1] && tick)) m_digit = (m_digit + 1) % (MAX_DIGIT + 1);
    else if (ev[1])                m_digit = (m_digit + MAX_DIGIT) % (MAX_DIGIT + 1);
    if (ev[0] || ev[1]) m_presc = 0;
    else if (m_run)     m_presc = (m_presc + 1) % TICK_DIV;
    if (ev[2]) m_run = !m_run;
    for (int b = 0; b < 3; b++) begin
      d = h2[b];
      h2[b] = h1[b];
      h1[b] = raw[b];
      if (d != lvl[b]) begin
        cnt[b]++;
        if (cnt[b] == DEB_CYCLES) begin
          cnt[b] = 0;
          lvl[b] = d;
          if (d) begin
            due_q[b].push_back(edge_no + 2);
            if (b < 2) begin
              rep_start[b] = edge_no + 2;
              rep_kill[b] = 32'h7fff_ffff;
            end
          end else if (b < 2) begin
            rep_kill[b] = edge_no + 2;
          end
        end
      end else begin
        cnt[b] = 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (edge_no > 0) begin
      check("digit", digit, m_digit);
      check("digit_chg", digit_chg, m_chg);
      check("running", running, m_run);
      check("digit_range", (digit <= MAX_DIGIT), 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input int b, input int hold);
    if (b == 0) btn_up_raw = 1'b1;
    else if (b == 1) btn_down_raw = 1'b1;
    else btn_run_raw = 1'b1;
    cyc(hold);
    btn_up_raw = 1'b0; btn_down_raw = 1'b0; btn_run_raw = 1'b0;
    cyc(hold);
  endtask

  initial begin
    cyc(3);
    check("rst_digit", digit, 0);
    check("rst_chg", digit_chg, 0);
    check("rst_running", running, 1);
    rst_n = 1'b1;

    // Free-running auto-advance.
    cyc(64);

    // Bouncy up press, then bouncy release.
    repeat (6) begin btn_up_raw = ~btn_up_raw; cyc(2); end
    btn_up_raw = 1'b1;
    cyc(20);
    repeat (5) begin btn_up_raw = ~btn_up_raw; cyc(2); end
    cyc(20);

    // Pause, then down/up wraps and simultaneous up+down.
    press_btn(2, 8);
    press_btn(1, 8);
    press_btn(0, 8);
    btn_up_raw = 1'b1; btn_down_raw = 1'b1;
    cyc(10);
    btn_up_raw = 1'b0; btn_down_raw = 1'b0;
    cyc(10);

    // Resume, pause for a long stretch, resume again.
    press_btn(2, 8);
    press_btn(2, 8);
    cyc(100);
    press_btn(2, 8);
    cyc(40);

    // Reset in the middle of a debounce.
    btn_up_raw = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    cyc(1);
    check("mid_rst_digit", digit, 0);
    check("mid_rst_chg", digit_chg, 0);
    check("mid_rst_running", running, 1);
    rst_n = 1'b1;
    btn_up_raw = 1'b0;
    cyc(30);

`ifdef AUTOREPEAT_EN
    btn_up_raw = 1'b1;   cyc(40); btn_up_raw = 1'b0;   cyc(20);
    btn_down_raw = 1'b1; cyc(33); btn_down_raw = 1'b0; cyc(20);
`endif

    // Randomized button activity with occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) btn_up_raw = ~btn_up_raw;
      if ($urandom_range(0, 3) == 0) btn_down_raw = ~btn_down_raw;
      if ($urandom_range(0, 5) == 0) btn_run_raw = ~btn_run_raw;
      rst_n = ($urandom_range(0, 60) != 0);
      cyc($urandom_range(1, 10));
    end
    rst_n = 1'b1;
    btn_up_raw = 1'b0; btn_down_raw = 1'b0; btn_run_raw = 1'b0;
    cyc(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
